// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave transmitter: SDA drive codes, controller states,
// and the state-to-SDA-mode decode used by the controller's Moore outputs.
package i2c_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        SDA_IDLE = 2'b00,
        SDA_ACK  = 2'b01,
        SDA_NACK = 2'b10,
        SDA_TX   = 2'b11
    } sda_mode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_END,
        ST_ACK_ADDR,
        ST_NACK_ADDR,
        ST_LOAD,
        ST_TX,
        ST_CHK_ACK,
        ST_ACK_END,
        ST_WAIT_STOP
    } ctrl_state_t;

    function automatic sda_mode_t mode_of(input ctrl_state_t st);
        case (st)
            ST_ACK_ADDR:    return SDA_ACK;
            ST_NACK_ADDR:   return SDA_NACK;
            ST_LOAD, ST_TX: return SDA_TX;
            default:        return SDA_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_slave_controller_if.sv
// Bus-event inputs and SDA/TX-path control outputs of the slave controller.
interface i2c_slave_controller_if;
    import i2c_pkg::*;

    logic      start_found;
    logic      stop_found;
    logic      rising_edge_found;
    logic      falling_edge_found;
    logic      sda_in;
    logic      fifo_empty;
    sda_mode_t sda_mode;
    logic      load_data;
    logic      read_enable;
    logic      tx_enable;

    modport slave (
        input  start_found, stop_found, rising_edge_found, falling_edge_found,
        input  sda_in, fifo_empty,
        output sda_mode, load_data, read_enable, tx_enable
    );

    modport master (
        output start_found, stop_found, rising_edge_found, falling_edge_found,
        output sda_in, fifo_empty,
        input  sda_mode, load_data, read_enable, tx_enable
    );
endinterface

// File: rtl/i2c_slave_controller_bit_counter.sv
// 4-bit bit counter: clear has priority, counts on enable and holds once a byte is complete.
module i2c_bit_counter
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] count,
    output logic       full
);
    logic [3:0] count_q;
    logic [3:0] count_d;

    assign full  = (count_q == 4'(BITS_PER_BYTE));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = 4'd0;
        else if (enable && !full)
            count_d = count_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst)
            count_q <= 4'd0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/i2c_slave_controller.sv
// Protocol FSM of the I2C slave transmitter: decodes address phase, ACK/NACK, byte
// transmission and master ACK, producing sda_mode and TX shift-register/FIFO strobes.
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    i2c_slave_controller_if.slave bus
);
    ctrl_state_t state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        ack_q, ack_d;
    logic        tx_q, tx_d;
    logic        cnt_clr, cnt_en, cnt_full, tx_full, addr_match;
    logic [3:0]  cnt;

    i2c_bit_counter u_bit_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cnt),
        .full   (cnt_full)
    );

    assign addr_match = (addr_q[7:1] == SLAVE_ADDR) && addr_q[0] && !bus.fifo_empty;
    // A rise coinciding with a fall is applied first, so the 8th rise ends the byte immediately.
    assign tx_full = cnt_full ||
                     (bus.rising_edge_found && (cnt == 4'(BITS_PER_BYTE - 1)));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ack_d   = ack_q;
        tx_d    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (bus.start_found) begin
            state_d = ST_ADDR;
            cnt_clr = 1'b1;
        end else if (bus.stop_found) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (cnt_full) begin
                        state_d = ST_ADDR_END;
                    end else if (bus.rising_edge_found) begin
                        addr_d = {addr_q[6:0], bus.sda_in};
                        cnt_en = 1'b1;
                    end
                end
                ST_ADDR_END:
                    if (bus.falling_edge_found)
                        state_d = addr_match ? ST_ACK_ADDR : ST_NACK_ADDR;
                ST_ACK_ADDR:
                    if (bus.falling_edge_found) state_d = ST_LOAD;
                ST_NACK_ADDR:
                    if (bus.falling_edge_found) state_d = ST_WAIT_STOP;
                ST_LOAD: begin
                    state_d = ST_TX;
                    cnt_clr = 1'b1;
                end
                ST_TX: begin
                    cnt_en = bus.rising_edge_found;
                    if (bus.falling_edge_found) begin
                        if (tx_full) state_d = ST_CHK_ACK;
                        else         tx_d    = 1'b1;
                    end
                end
                ST_CHK_ACK:
                    if (bus.rising_edge_found) begin
                        ack_d   = !bus.sda_in;
                        state_d = ST_ACK_END;
                    end
                ST_ACK_END:
                    if (bus.falling_edge_found)
                        state_d = (ack_q && !bus.fifo_empty) ? ST_LOAD : ST_WAIT_STOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            ack_q   <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.sda_mode    = mode_of(state_q);
    assign bus.load_data   = (state_q == ST_LOAD);
    assign bus.read_enable = (state_q == ST_LOAD);
    assign bus.tx_enable   = tx_q;
endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed table-driven bench: each row is one clock of bus events with the outputs
// expected one clock later.
module tb_i2c_slave_controller;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    i2c_slave_controller_if bus_if ();

    i2c_slave_controller #(.SLAVE_ADDR(7'b1111000)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    typedef struct {
        logic       rst_n;
        logic       st;
        logic       sp;
        logic       r;
        logic       f;
        logic       sda;
        logic       fe;
        logic [1:0] mode;
        logic       ld;
        logic       tx;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step(input logic rst_n, st, sp, r, f, sda, fe,
                        input logic [1:0] mode, input logic ld, tx);
        vec_t v;
        v.rst_n = rst_n; v.st = st; v.sp = sp; v.r = r; v.f = f;
        v.sda = sda; v.fe = fe; v.mode = mode; v.ld = ld; v.tx = tx;
        vq.push_back(v);
    endtask

    // One SCL period: rise, gap, fall, gap.
    task automatic bitclk(input logic sda, fe, input logic [1:0] m_r, m_f,
                          input logic ld_f, tx_f);
        step(1, 0, 0, 1, 0, sda, fe, m_r, 0, 0);
        step(1, 0, 0, 0, 0, sda, fe, m_r, 0, 0);
        step(1, 0, 0, 0, 1, sda, fe, m_f, ld_f, tx_f);
        step(1, 0, 0, 0, 0, sda, fe, ld_f ? 2'b11 : m_f, 0, 0);
    endtask

    task automatic addr_byte(input logic [7:0] b, input logic fe, input logic [1:0] last_mode);
        for (int i = 7; i >= 0; i--)
            bitclk(b[i], fe, 2'b00, (i == 0) ? last_mode : 2'b00, 0, 0);
    endtask

    task automatic data_byte();
        for (int i = 0; i < 7; i++) bitclk(1, 0, 2'b11, 2'b11, 0, 1);
        bitclk(1, 0, 2'b11, 2'b00, 0, 0);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got mode=%b ld=%b re=%b tx=%b, required mode=%b ld=%b re=%b tx=%b",
                     name, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus_if.sda_mode, bus_if.load_data, bus_if.read_enable, bus_if.tx_enable};
    endfunction

    initial begin
        // 1 + 4: read 0xF1, ACK, byte, master ACK -> reload, byte, master NACK, stop
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        bitclk(0, 0, 2'b01, 2'b11, 1, 0);
        data_byte();
        bitclk(0, 0, 2'b00, 2'b11, 1, 0);
        data_byte();
        bitclk(1, 0, 2'b00, 2'b00, 0, 0);
        bitclk(0, 0, 2'b00, 2'b00, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        // 2: start+stop together (start wins), write address -> NACK, WAIT_STOP
        step(1, 1, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF0, 0, 2'b10);
        bitclk(1, 0, 2'b10, 2'b00, 0, 0);
        bitclk(0, 0, 2'b00, 2'b00, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        // 3: address mismatch, then matching read with empty FIFO
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hA3, 0, 2'b10);
        bitclk(1, 0, 2'b10, 2'b00, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        step(1, 1, 0, 0, 0, 1, 1, 2'b00, 0, 0);
        addr_byte(8'hF1, 1, 2'b10);
        bitclk(1, 1, 2'b10, 2'b00, 0, 0);
        step(1, 0, 1, 0, 0, 1, 1, 2'b00, 0, 0);
        // 4b: master ACK but FIFO empty -> WAIT_STOP
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        bitclk(0, 0, 2'b01, 2'b11, 1, 0);
        data_byte();
        bitclk(0, 1, 2'b00, 2'b00, 0, 0);
        bitclk(0, 1, 2'b00, 2'b00, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        // 5: repeated START on the falling edge after bit 4 of TX
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        bitclk(0, 0, 2'b01, 2'b11, 1, 0);
        for (int i = 0; i < 3; i++) bitclk(1, 0, 2'b11, 2'b11, 0, 1);
        step(1, 0, 0, 1, 0, 1, 0, 2'b11, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0);
        step(1, 1, 0, 0, 1, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        bitclk(0, 0, 2'b01, 2'b11, 1, 0);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);
        // 6: reset during ACK_ADDR with a falling edge; SCL then ignored until START
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        step(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
        bitclk(1, 0, 2'b00, 2'b00, 0, 0);
        bitclk(0, 0, 2'b00, 2'b00, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        addr_byte(8'hF1, 0, 2'b01);
        step(1, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0);

        // Reset state, with a START pulse present that must be ignored
        n_rst = 1'b0;
        bus_if.start_found = 1'b1; bus_if.stop_found = 1'b0;
        bus_if.rising_edge_found = 1'b0; bus_if.falling_edge_found = 1'b0;
        bus_if.sda_in = 1'b1; bus_if.fifo_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), 5'b00000);
        bus_if.start_found = 1'b0;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", outs(), 5'b00000);

        for (int i = 0; i < vq.size(); i++) begin
            n_rst                     = vq[i].rst_n;
            bus_if.start_found        = vq[i].st;
            bus_if.stop_found         = vq[i].sp;
            bus_if.rising_edge_found  = vq[i].r;
            bus_if.falling_edge_found = vq[i].f;
            bus_if.sda_in             = vq[i].sda;
            bus_if.fifo_empty         = vq[i].fe;
            @(posedge clk);
            #1;
            $display("vec %0d: rst_n=%b st=%b sp=%b r=%b f=%b sda=%b fe=%b -> mode=%b ld=%b re=%b tx=%b",
                     i, vq[i].rst_n, vq[i].st, vq[i].sp, vq[i].r, vq[i].f, vq[i].sda, vq[i].fe,
                     bus_if.sda_mode, bus_if.load_data, bus_if.read_enable, bus_if.tx_enable);
            check($sformatf("vec%0d", i), outs(),
                  {vq[i].mode, vq[i].ld, vq[i].ld, vq[i].tx});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
